// File: rtl/idct_pkg.sv
// Shared types and defaults for the IDCT pixel sink: FSM state encoding,
// block/fraction defaults and the 8-bit pixel type.
package idct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam int BLK_DEF  = 64;
  localparam int FRAC_DEF = 10;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/pix_fifo.sv
// Pixel FIFO with a registered head: a word written at edge N is presented
// on o_rd_data after edge N+1. The head register counts toward DEPTH.
module pix_fifo
  import idct_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = PIX_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_rd_valid,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;

  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic [AW:0]   w_total;

  // Writes are refused when full even if the head is leaving this cycle.
  assign w_total = r_mem_cnt + {{AW{1'b0}}, r_out_valid};
  assign o_full  = (w_total == (AW+1)'(DEPTH));
  assign o_empty = (w_total == '0);
  assign w_push  = i_wr_en & ~o_full;
  assign w_pop   = i_rd_en & r_out_valid;
  assign w_load  = (r_mem_cnt != '0) & (~r_out_valid | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_mem_cnt <= r_mem_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_load};
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_rd_data  = r_out_data;
  assign o_rd_valid = r_out_valid;

endmodule

// File: rtl/idct_pix_sink.sv
// Collects IDCT output samples into 8-bit pixels, tags block ends and buffers
// them for a valid/ready consumer. Define IDCT_PIX_SAT_EN for saturating conversion.
module idct_pix_sink
  import idct_pkg::*;
#(
  parameter int DW    = 32,
  parameter int FRAC  = FRAC_DEF,
  parameter int DEPTH = 16,
  parameter int BLK   = BLK_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done,
  input  logic [DW-1:0] din,
  input  logic          pix_ready,
  output logic [7:0]    pix_out,
  output logic          pix_valid,
  output logic [15:0]   blk_cnt,
  output logic          blk_last,
  output logic          overflow,
  output logic          busy,
  output logic [1:0]    o_dbg_state
);

  localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_smp_cnt;
  logic [CW-1:0] w_smp_cnt_nx;
  logic [15:0]   r_blk_cnt;
  logic          r_overflow;
  logic          w_accept;
  logic          w_last;
  logic          w_full;
  logic          w_empty;
  logic          w_rd_valid;
  logic [8:0]    w_rd_data;
  pix_t          w_pix;
  logic          w_unused_bits;

`ifdef IDCT_PIX_SAT_EN
  always_comb begin
    w_pix = din[FRAC+7:FRAC];
    if (din[DW-1])                w_pix = '0;
    else if (|din[DW-2:FRAC+8])   w_pix = '1;
  end
`else
  assign w_pix = din[FRAC+7:FRAC];
`endif

  assign w_unused_bits = ^{din[DW-1:FRAC+8], din[FRAC-1:0]};

  always_comb begin
    w_state_nx   = r_state;
    w_smp_cnt_nx = r_smp_cnt;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (done) begin
          w_accept = 1'b1;
          if (r_smp_cnt == CW'(BLK-1)) begin
            w_last       = 1'b1;
            w_smp_cnt_nx = '0;
            w_state_nx   = ST_HOLD;
          end else begin
            w_smp_cnt_nx = r_smp_cnt + CW'(1);
            w_state_nx   = ST_COLLECT;
          end
        end else begin
          // A short block is abandoned without touching blk_cnt.
          w_smp_cnt_nx = '0;
          w_state_nx   = ST_IDLE;
        end
      end
      ST_HOLD: if (!done) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_smp_cnt  <= '0;
      r_blk_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_smp_cnt <= w_smp_cnt_nx;
      if (w_last)            r_blk_cnt  <= r_blk_cnt + 16'd1;
      if (w_accept & w_full) r_overflow <= 1'b1;
    end
  end

  pix_fifo #(
    .DEPTH(DEPTH),
    .W    (PIX_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_data ({w_last, w_pix}),
    .i_rd_en   (pix_ready),
    .o_rd_data (w_rd_data),
    .o_rd_valid(w_rd_valid),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign pix_out     = w_rd_data[7:0];
  assign pix_valid   = w_rd_valid;
  assign blk_last    = w_rd_data[8] & w_rd_valid;
  assign blk_cnt     = r_blk_cnt;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE) | ~w_empty;
  assign o_dbg_state = r_state;

endmodule
